fetch_queue: RTL and testbench

//  Instruction-fetch front end feeding the IF/ID pipeline registers. Owns the PC and issues

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and the queue entry layout for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int          INSTR_W = 32;
  localparam int          ADDR_W  = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pcnext;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pcnext} with a one-cycle flush.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t         rd_ptr;
  ptr_t         wr_ptr;
  fetch_entry_t mem [DEPTH];

  assign head = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  // NOTE: non-blocking assignments keep every register update based on pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, single-outstanding imem reads, redirect flush, output queue.
// Define FETCH_BYPASS_EN to let a response reach the outputs in its arrival cycle when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pcnext
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc;
  logic [31:0]      req_pc;
  logic             inflight;
  logic             drop;

  logic             push;
  logic             pop;
  logic             issue;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] occ_next;
  fetch_entry_t     new_entry;
  fetch_entry_t     fifo_head;
  fetch_entry_t     head_sel;

  assign new_entry  = '{instr: imem_rdata, pcnext: req_pc + PC_INC};
  assign fifo_empty = (fifo_count == '0);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    push      = imem_valid & inflight & ~drop & ~redirect;
    out_valid = ~fifo_empty;
    head_sel  = fifo_head;
    fifo_push = push;
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && push) begin
      out_valid = 1'b1;
      head_sel  = new_entry;
      fifo_push = hold;
    end
`endif
    pop      = out_valid & ~hold & ~redirect;
    fifo_pop = pop & ~fifo_empty;
    occ_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    issue    = ~redirect & (~inflight | imem_valid) & (occ_next < DEPTH_C);
  end

  // Reset is asynchronous, so the request is masked combinationally while it is held.
  assign imem_req   = issue & ~rst;
  assign imem_addr  = pc;
  assign out_instr  = out_valid ? head_sel.instr  : NOP_WORD;
  assign out_pcnext = out_valid ? head_sel.pcnext : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= align_pc(RESET_PC);
      req_pc   <= align_pc(RESET_PC);
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else if (redirect) begin
      pc       <= align_pc(redirect_pc);
      // A request still outstanding must have its eventual response thrown away.
      inflight <= inflight & ~imem_valid;
      drop     <= inflight & ~imem_valid;
    end else begin
      if (issue) begin
        pc       <= pc + PC_INC;
        req_pc   <= pc;
        inflight <= 1'b1;
      end else if (imem_valid) begin
        inflight <= 1'b0;
      end
      if (imem_valid && inflight) drop <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect),
    .wr_data (new_entry),
    .head    (fifo_head),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4, RESET_PC=0, NOP_WORD=0).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pcnext;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pcnext  (out_pcnext)
  );

  typedef struct {
    logic        iv;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] rpc;
    logic        hold;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] oi;
    logic [31:0] opn;
  } vec_t;

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002;
  localparam logic [31:0] A3 = 32'hA000_0003, A4 = 32'hA000_0004, A5 = 32'hA000_0005;
  localparam logic [31:0] A6 = 32'hA000_0006, A7 = 32'hA000_0007;
  localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, B2 = 32'hB000_0002;
  localparam logic [31:0] C0 = 32'hC000_0000, D0 = 32'hD000_0000, E0 = 32'hE000_0000;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] rdata, input logic rd,
                     input logic [31:0] rpc, input logic hd, input logic req,
                     input logic [31:0] addr, input logic ov, input logic [31:0] oi,
                     input logic [31:0] opn);
    vecs.push_back('{iv, rdata, rd, rpc, hd, req, addr, ov, oi, opn});
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic req,
                               input logic [31:0] addr, input logic ov,
                               input logic [31:0] oi, input logic [31:0] opn);
    check({tag, ".imem_req"}, idx, {31'b0, imem_req}, {31'b0, req});
    if (req) check({tag, ".imem_addr"}, idx, imem_addr, addr);
    check({tag, ".out_valid"}, idx, {31'b0, out_valid}, {31'b0, ov});
    check({tag, ".out_instr"}, idx, out_instr, oi);
    check({tag, ".out_pcnext"}, idx, out_pcnext, opn);
  endtask

  initial begin
`ifdef FETCH_BYPASS_EN
    // Empty queue: a response is visible the cycle it arrives; with hold it is also queued.
    add(0, 0,  0, 0, 0,  1, 32'h0, 0, 0,  0);
    add(1, A0, 0, 0, 0,  1, 32'h4, 1, A0, 32'h4);
    add(0, 0,  0, 0, 0,  0, 0,     0, 0,  0);
    add(1, A1, 0, 0, 1,  1, 32'h8, 1, A1, 32'h8);
    add(0, 0,  0, 0, 0,  0, 0,     1, A1, 32'h8);
    add(0, 0,  0, 0, 0,  0, 0,     0, 0,  0);
`else
    // Stream with 1-cycle memory
    add(0, 0,  0, 0, 0,  1, 32'h0,  0, 0,  0);
    add(1, A0, 0, 0, 0,  1, 32'h4,  0, 0,  0);
    add(1, A1, 0, 0, 0,  1, 32'h8,  1, A0, 32'h4);
    add(1, A2, 0, 0, 0,  1, 32'hC,  1, A1, 32'h8);
    add(1, A3, 0, 0, 0,  1, 32'h10, 1, A2, 32'hC);
    // Hold until the queue is full, then release and drain
    add(1, A4, 0, 0, 1,  1, 32'h14, 1, A3, 32'h10);
    add(1, A5, 0, 0, 1,  1, 32'h18, 1, A3, 32'h10);
    add(1, A6, 0, 0, 1,  0, 0,      1, A3, 32'h10);
    add(0, 0,  0, 0, 1,  0, 0,      1, A3, 32'h10);
    add(0, 0,  0, 0, 1,  0, 0,      1, A3, 32'h10);
    add(0, 0,  0, 0, 0,  1, 32'h1C, 1, A3, 32'h10);
    add(1, A7, 0, 0, 0,  1, 32'h20, 1, A4, 32'h14);
    add(0, 0,  0, 0, 0,  0, 0,      1, A5, 32'h18);
    // Redirect to 0x103 while the 0x20 fetch is in flight (3-cycle latency)
    add(0, 0,   1, 32'h0000_0103, 0,  0, 0, 1, A6, 32'h1C);
    add(1, BAD, 0, 0, 0,  1, 32'h100, 0, 0,  0);
    add(1, B0,  0, 0, 0,  1, 32'h104, 0, 0,  0);
    add(0, 0,   0, 0, 1,  0, 0,       1, B0, 32'h104);
    // Redirect coinciding with a response, hold=1, count=2
    add(1, B1,  0, 0, 1,  1, 32'h108, 1, B0, 32'h104);
    add(1, B2,  1, 32'h0000_0200, 1,  0, 0, 1, B0, 32'h104);
    add(0, 0,   0, 0, 1,  1, 32'h200, 0, 0,  0);
    add(1, C0,  0, 0, 0,  1, 32'h204, 0, 0,  0);
    add(0, 0,   0, 0, 0,  0, 0,       1, C0, 32'h204);
    add(0, 0,   0, 0, 0,  0, 0,       0, 0,  0);
    // PC and pcnext wrap at the top of the address space
    add(0, 0,   1, 32'hFFFF_FFFC, 0,  0, 0, 0, 0, 0);
    add(1, BAD, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 0, 0);
    add(1, D0,  0, 0, 0,  1, 32'h0, 0, 0,  0);
    add(0, 0,   0, 0, 0,  0, 0,     1, D0, 32'h0);
    add(0, 0,   0, 0, 0,  0, 0,     0, 0,  0);
`endif

    rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; hold = 1'b0;
    @(negedge clk);
    check_outputs("reset", 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      imem_valid  = vecs[i].iv;
      imem_rdata  = vecs[i].rdata;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      hold        = vecs[i].hold;
      #1;
      check_outputs("vec", i, vecs[i].req, vecs[i].addr, vecs[i].ov, vecs[i].oi, vecs[i].opn);
      @(negedge clk);
    end

    // Mid-run asynchronous reset with a response arriving and a request in flight
    imem_valid = 1'b1; imem_rdata = E0; redirect = 1'b0; hold = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_outputs("midrst", 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_outputs("midrst", 1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0; imem_valid = 1'b0; hold = 1'b0;
    #1;
    check_outputs("postrst", 0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = E0;
    #1;
    check_outputs("postrst", 1, 1'b1, 32'h4, 1'b0 | `ifdef FETCH_BYPASS_EN 1'b1 `else 1'b0 `endif,
                  `ifdef FETCH_BYPASS_EN E0 `else 32'h0 `endif,
                  `ifdef FETCH_BYPASS_EN 32'h4 `else 32'h0 `endif);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
